// File: rtl/counter.sv
// ----------------------------------------------------------------------------
// counter
//
// Loadable down-counter with a configurable step. A WIDTH-bit start value is
// loaded on latch; afterwards the count drops by DEC_COUNT on every rising
// clock edge while dec is high. A partial final step saturates at 0 instead
// of wrapping. zero is a direct decode of the count register, so it moves in
// the same cycle as the count. Typical use: round/byte countdowns in a hash
// datapath.
//
// Optional feature macro: COUNTER_UNDERFLOW_EN
//   defined   -> adds output underflow, a registered one-cycle pulse flagging
//                an enabled decrement that could not take a full step
//                (a saturated partial step, or dec while already at 0).
//   undefined -> no underflow port and no extra logic.
//
// Parameters
//   WIDTH      width of in and of the internal count
//   DEC_COUNT  step subtracted per enabled cycle, 1..2**WIDTH-1
//
// Ports
//   clock      in   1      sole clock, rising edge
//   reset_n    in   1      asynchronous active-low reset (count -> 0)
//   in         in   WIDTH  value loaded when latch = 1
//   latch      in   1      synchronous load strobe, beats dec
//   dec        in   1      decrement enable, level-sensitive
//   zero       out  1      1 while count == 0
//   underflow  out  1      only with COUNTER_UNDERFLOW_EN
// ----------------------------------------------------------------------------
module counter #(
   parameter int WIDTH     = 4,
   parameter int DEC_COUNT = 1
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] in,
   input  logic             latch,
   input  logic             dec,
   output logic             zero
`ifdef COUNTER_UNDERFLOW_EN
   ,
   output logic             underflow
`endif
);

   // Step expressed at the count width so every compare/subtract stays
   // unsigned WIDTH-bit arithmetic.
   localparam logic [WIDTH-1:0] STEP = WIDTH'(DEC_COUNT);

   logic [WIDTH-1:0] r_count;
   logic [WIDTH-1:0] w_count_next;
   logic             w_full_step;

   // A full step is only possible when it cannot go below zero; otherwise
   // the count saturates at 0.
   assign w_full_step = (r_count >= STEP);

   always_comb begin
      w_count_next = r_count;
      if (latch) begin
         w_count_next = in;
      end else if (dec) begin
         if (w_full_step) begin
            w_count_next = r_count - STEP;
         end else begin
            w_count_next = '0;
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_count <= '0;
      end else begin
         r_count <= w_count_next;
      end
   end

   assign zero = (r_count == '0);

`ifdef COUNTER_UNDERFLOW_EN
   logic r_underflow;

   // An enabled decrement without a full step covers both the saturated
   // partial step and dec while already at 0 (0 < STEP since STEP >= 1).
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_underflow <= 1'b0;
      end else begin
         r_underflow <= !latch && dec && !w_full_step;
      end
   end

   assign underflow = r_underflow;
`endif

endmodule

// File: tb/tb_counter.sv
module tb_counter;

   localparam int W = 4;
   localparam int D = 2;

   logic         clock   = 1'b0;
   logic         reset_n = 1'b0;
   logic [W-1:0] in_v    = '0;
   logic         latch   = 1'b0;
   logic         dec     = 1'b0;
   logic         zero;
`ifdef COUNTER_UNDERFLOW_EN
   logic         underflow;
`endif

   counter #(.WIDTH(W), .DEC_COUNT(D)) dut (
      .clock    (clock),
      .reset_n  (reset_n),
      .in       (in_v),
      .latch    (latch),
      .dec      (dec),
      .zero     (zero)
`ifdef COUNTER_UNDERFLOW_EN
      ,
      .underflow(underflow)
`endif
   );

   always #5 clock = ~clock;

   int checks   = 0;
   int failures = 0;

   // Reference model: the count as a plain integer, updated from the
   // behavioural rules (load, else max(count - step, 0) when enabled).
   int m_count = 0;
   bit m_uf    = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, "_count"}, 32'(dut.r_count), 32'(m_count));
      check({tag, "_zero"}, 32'(zero), 32'(m_count == 0));
`ifdef COUNTER_UNDERFLOW_EN
      check({tag, "_uf"}, 32'(underflow), 32'(m_uf));
`endif
   endtask

   task automatic step(input bit l, input int v, input bit d, input string tag);
      @(negedge clock);
      latch = l;
      in_v  = W'(v);
      dec   = d;
      @(posedge clock);
      if (l) begin
         m_count = v % (1 << W);
         m_uf    = 1'b0;
      end else if (d) begin
         m_uf    = (m_count < D);
         m_count = (m_count - D < 0) ? 0 : m_count - D;
      end else begin
         m_uf = 1'b0;
      end
      #1;
      check_all(tag);
      $display("step %s latch=%0b in=%0d dec=%0b -> model count=%0d", tag, l, v, d, m_count);
   endtask

   initial begin
      // Reset held across clock edges.
      reset_n = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      check_all("reset_held");
      @(negedge clock);
      reset_n = 1'b1;
      @(posedge clock);
      #1;
      check_all("reset_released");

      // Load 12, count down by 2 to 0, then keep dec high at 0.
      step(1, 12, 0, "load12");
      for (int i = 1; i <= 6; i++) step(0, 0, 1, $sformatf("dec12_%0d", i));
      step(0, 0, 1, "dec_at_zero");

      // Saturation: 5 -> 3 -> 1 -> 0, then two more dec cycles at 0.
      step(1, 5, 0, "load5");
      for (int i = 1; i <= 5; i++) step(0, 0, 1, $sformatf("sat_%0d", i));

      // Load beats simultaneous dec.
      step(1, 9, 1, "prio_load9");
      step(0, 0, 1, "prio_dec");

      // Hold, then load zero.
      step(1, 6, 0, "load6");
      for (int i = 1; i <= 5; i++) step(0, 0, 0, $sformatf("hold_%0d", i));
      step(1, 0, 0, "load0");

      // Asynchronous reset between edges mid-countdown.
      step(1, 12, 0, "load12b");
      step(0, 0, 1, "run_1");
      step(0, 0, 1, "run_2");
      @(negedge clock);
      #2;
      reset_n = 1'b0;
      m_count = 0;
      m_uf    = 1'b0;
      #1;
      check_all("async_reset");
      @(negedge clock);
      reset_n = 1'b1;
      step(0, 0, 0, "after_reset_idle");
      step(0, 0, 1, "after_reset_dec");

      // Randomized traffic against the model.
      for (int i = 0; i < 300; i++) begin
         step(($urandom_range(0, 3) == 0), $urandom_range(0, (1 << W) - 1),
              ($urandom_range(0, 3) != 0), $sformatf("rand_%0d", i));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
